// File: rtl/intra_pkg.sv
// Shared types and constants for the intra edge gather block.
// Pixel layout: Y[9:0], U[19:10], V[29:20].
// Also holds the neutral fill levels and the gather FSM state encoding.
package intra_pkg;

  localparam int PIX_W  = 30;
  localparam int COMP_W = 10;
  localparam int Y_LSB  = 0;
  localparam int U_LSB  = 10;
  localparam int V_LSB  = 20;

  // Neutral levels for a 10-bit component: below-mid, mid, above-mid.
  localparam logic [COMP_W-1:0] PIX_BELOW = 10'd511;
  localparam logic [COMP_W-1:0] PIX_MID   = 10'd512;
  localparam logic [COMP_W-1:0] PIX_ABOVE = 10'd513;

  typedef struct packed {
    logic [COMP_W-1:0] v;
    logic [COMP_W-1:0] u;
    logic [COMP_W-1:0] y;
  } pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_EDGE,
    ST_FETCH_CORNER,
    ST_FILL,
    ST_PRESENT
  } state_e;

  // Same value in all three components.
  function automatic pixel_t pix_splat(input logic [COMP_W-1:0] c);
    return '{v: c, u: c, y: c};
  endfunction

endpackage

// File: rtl/intra_edge_strength_sel.sv
// Smoothing filter strength from block size (w+h), angle delta and filter type.
// Purely combinational; no state, no latency.
// Larger blocks and larger angle deltas select stronger smoothing.
import intra_pkg::*;

module intra_edge_strength_sel (
  input  logic [7:0] blk_wh,
  input  logic [6:0] d,
  input  logic       filter_type,
  output logic [1:0] strength
);

  // Threshold ladder per block-size class; first matching class wins.
  always_comb begin
    strength = 2'd0;
    if (!filter_type) begin
      if (blk_wh <= 8'd8) begin
        if (d >= 7'd56) strength = 2'd1;
      end else if (blk_wh <= 8'd16) begin
        if (d >= 7'd40) strength = 2'd1;
      end else if (blk_wh <= 8'd24) begin
        if      (d >= 7'd32) strength = 2'd3;
        else if (d >= 7'd16) strength = 2'd2;
        else if (d >= 7'd8)  strength = 2'd1;
      end else if (blk_wh <= 8'd32) begin
        if      (d >= 7'd32) strength = 2'd3;
        else if (d >= 7'd4)  strength = 2'd2;
        else if (d >= 7'd1)  strength = 2'd1;
      end else begin
        if (d >= 7'd1) strength = 2'd3;
      end
    end else begin
      if (blk_wh <= 8'd8) begin
        if      (d >= 7'd64) strength = 2'd2;
        else if (d >= 7'd40) strength = 2'd1;
      end else if (blk_wh <= 8'd16) begin
        if      (d >= 7'd48) strength = 2'd2;
        else if (d >= 7'd20) strength = 2'd1;
      end else if (blk_wh <= 8'd24) begin
        if (d >= 7'd4) strength = 2'd3;
      end else begin
        if (d >= 7'd1) strength = 2'd3;
      end
    end
  end

endmodule

// File: rtl/intra_edge_gather.sv
// Gathers one intra-prediction edge (left column or above row) plus corner pixel.
// Latency: out_valid rises reads*(1+wait)+2 cycles after start; 1 read in flight.
// Reads wait on rd_valid; the presented set is held until out_ready.
import intra_pkg::*;

module intra_edge_gather #(
  parameter int SIZE      = 8,
  parameter int BIT_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_left,
  input  logic                 edge_avail,
  input  logic                 corner_avail,
  input  logic [3:0]           num_avail,
  input  logic [7:0]           blk_wh,
  input  logic [6:0]           angle_delta,
  input  logic                 filter_type,
  output logic                 rd_req,
  output logic [3:0]           rd_addr,
  input  logic                 rd_valid,
  input  logic [29:0]          rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [29:0]          reference_pixel,
  output logic [30*SIZE-1:0]   edge_array,
  output logic [9:0]           filter_strength
);

  localparam logic [3:0] CORNER_ADDR = 4'(SIZE);
  localparam logic [3:0] SIZE_4      = 4'(SIZE);

  // Neutral levels follow BIT_DEPTH; the package values cover the native depth.
  localparam logic [COMP_W-1:0] VAL_MID =
    (BIT_DEPTH == COMP_W) ? PIX_MID : COMP_W'(1 << (BIT_DEPTH - 1));
  localparam logic [COMP_W-1:0] VAL_BELOW =
    (BIT_DEPTH == COMP_W) ? PIX_BELOW : VAL_MID - COMP_W'(1);
  localparam logic [COMP_W-1:0] VAL_ABOVE =
    (BIT_DEPTH == COMP_W) ? PIX_ABOVE : VAL_MID + COMP_W'(1);

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d, n_clamped;
  logic        is_left_q, is_left_d;
  logic        edge_avail_q, edge_avail_d;
  logic        corner_avail_q, corner_avail_d;
  logic        rd_req_q, rd_req_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  strength_q, strength_d, strength_sel;
  pixel_t      ref_q, ref_d;
  pixel_t      last_pix, fill_pix;
  pixel_t      edge_q [SIZE];
  pixel_t      edge_d [SIZE];

  intra_edge_strength_sel u_strength (
    .blk_wh      (blk_wh),
    .d           (angle_delta),
    .filter_type (filter_type),
    .strength    (strength_sel)
  );

  // Clamp the readable-pixel count into 1..SIZE.
  always_comb begin
    if (num_avail == 4'd0)        n_clamped = 4'd1;
    else if (num_avail > SIZE_4)  n_clamped = SIZE_4;
    else                          n_clamped = num_avail;
  end

  // Next-state and datapath updates for the gather sequence.
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    is_left_d      = is_left_q;
    edge_avail_d   = edge_avail_q;
    corner_avail_d = corner_avail_q;
    rd_req_d       = rd_req_q;
    rd_addr_d      = rd_addr_q;
    out_valid_d    = out_valid_q;
    strength_d     = strength_q;
    ref_d          = ref_q;
    edge_d         = edge_q;
    fill_pix       = pix_splat(is_left_q ? VAL_ABOVE : VAL_BELOW);

    // Last fetched pixel is the padding source for the unread tail.
    last_pix = edge_q[0];
    for (int i = 0; i < SIZE; i++) begin
      if (4'(i) == n_q - 4'd1) last_pix = edge_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d            = n_clamped;
          is_left_d      = is_left;
          edge_avail_d   = edge_avail;
          corner_avail_d = corner_avail;
          strength_d     = strength_sel;
          if (edge_avail) begin
            state_d   = ST_FETCH_EDGE;
            rd_req_d  = 1'b1;
            rd_addr_d = 4'd0;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_FETCH_EDGE: begin
        if (rd_req_q && rd_valid) begin
          for (int i = 0; i < SIZE; i++) begin
            if (rd_addr_q == 4'(i)) edge_d[i] = pixel_t'(rd_data);
          end
          if (rd_addr_q == n_q - 4'd1) begin
            if (corner_avail_q) begin
              state_d   = ST_FETCH_CORNER;
              rd_addr_d = CORNER_ADDR;
            end else begin
              state_d   = ST_FILL;
              rd_req_d  = 1'b0;
              rd_addr_d = 4'd0;
            end
          end else begin
            rd_addr_d = rd_addr_q + 4'd1;
          end
        end
      end

      ST_FETCH_CORNER: begin
        if (rd_req_q && rd_valid) begin
          ref_d     = pixel_t'(rd_data);
          rd_req_d  = 1'b0;
          rd_addr_d = 4'd0;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        for (int i = 0; i < SIZE; i++) begin
          if (!edge_avail_q)       edge_d[i] = fill_pix;
          else if (4'(i) >= n_q)   edge_d[i] = last_pix;
        end
        if (!edge_avail_q)         ref_d = pix_splat(VAL_MID);
        else if (!corner_avail_q)  ref_d = edge_q[0];
        out_valid_d = 1'b1;
        state_d     = ST_PRESENT;
      end

      ST_PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      n_q            <= 4'd1;
      is_left_q      <= 1'b0;
      edge_avail_q   <= 1'b0;
      corner_avail_q <= 1'b0;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= 4'd0;
      out_valid_q    <= 1'b0;
      strength_q     <= 2'd0;
      ref_q          <= '0;
      for (int i = 0; i < SIZE; i++) edge_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      is_left_q      <= is_left_d;
      edge_avail_q   <= edge_avail_d;
      corner_avail_q <= corner_avail_d;
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      out_valid_q    <= out_valid_d;
      strength_q     <= strength_d;
      ref_q          <= ref_d;
      edge_q         <= edge_d;
    end
  end

  assign rd_req          = rd_req_q;
  assign rd_addr         = rd_addr_q;
  assign out_valid       = out_valid_q;
  assign reference_pixel = ref_q;
  assign filter_strength = {8'd0, strength_q};

  for (genvar g = 0; g < SIZE; g++) begin : g_edge_out
    assign edge_array[g*30 +: 30] = edge_q[g];
  end

endmodule

// File: tb/tb_intra_edge_gather.sv
// Randomized and directed checks of intra_edge_gather against a reference model.
// Read responder inserts a configurable wait per read; consumer stalls randomly.
// A monitor checks read-request and presented-output stability.
module tb_intra_edge_gather;

  localparam int SIZE = 8;

  logic                clk = 1'b0;
  logic                reset, start, is_left, edge_avail, corner_avail;
  logic [3:0]          num_avail;
  logic [7:0]          blk_wh;
  logic [6:0]          angle_delta;
  logic                filter_type;
  logic                rd_req;
  logic [3:0]          rd_addr;
  logic                rd_valid;
  logic [29:0]         rd_data;
  logic                out_valid, out_ready;
  logic [29:0]         reference_pixel;
  logic [30*SIZE-1:0]  edge_array;
  logic [9:0]          filter_strength;

  intra_edge_gather #(.SIZE(SIZE), .BIT_DEPTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .is_left(is_left),
    .edge_avail(edge_avail), .corner_avail(corner_avail), .num_avail(num_avail),
    .blk_wh(blk_wh), .angle_delta(angle_delta), .filter_type(filter_type),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .reference_pixel(reference_pixel),
    .edge_array(edge_array), .filter_strength(filter_strength)
  );

  always #5 clk = ~clk;

  // Neighbour memory: 0..SIZE-1 edge, SIZE corner.
  logic [29:0] mem [0:SIZE];
  int          lat_cfg = 0;
  int          wait_cnt = 0;
  logic        late_valid = 1'b0;

  assign rd_valid = (rd_req && (wait_cnt >= lat_cfg)) || late_valid;
  assign rd_data  = mem[rd_addr];

  always @(posedge clk) begin
    if (rd_req && !rd_valid) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] splat(input logic [9:0] c);
    return {c, c, c};
  endfunction

  // Strength = number of thresholds d reaches in the first size class that fits.
  int lim [5]    = '{8, 16, 24, 32, 255};
  int th0 [5][3] = '{'{56, 999, 999}, '{40, 999, 999}, '{8, 16, 32}, '{1, 4, 32}, '{1, 1, 1}};
  int th1 [5][3] = '{'{40, 64, 999}, '{20, 48, 999}, '{4, 4, 4}, '{1, 1, 1}, '{1, 1, 1}};

  function automatic int model_strength(input int wh, input int d, input bit ft);
    int r, s;
    r = 0;
    while (wh > lim[r]) r++;
    s = 0;
    for (int k = 0; k < 3; k++) s += (d >= (ft ? th1[r][k] : th0[r][k])) ? 1 : 0;
    return s;
  endfunction

  // Stability monitor: pending read and stalled output must not move.
  logic               pend_rd = 1'b0, pend_out = 1'b0;
  logic [3:0]         pend_addr;
  logic [29:0]        pend_ref;
  logic [30*SIZE-1:0] pend_edge;
  logic [9:0]         pend_str;

  always @(negedge clk) begin
    #1;
    if (pend_rd) begin
      chk("rd_req_hold", rd_req, 1'b1);
      chk("rd_addr_hold", rd_addr, pend_addr);
    end
    if (pend_out) begin
      chk("out_valid_hold", out_valid, 1'b1);
      chk("edge_hold", edge_array, pend_edge);
      chk("ref_hold", reference_pixel, pend_ref);
      chk("str_hold", filter_strength, pend_str);
    end
    pend_rd   = rd_req && !rd_valid && !reset;
    pend_addr = rd_addr;
    pend_out  = out_valid && !out_ready && !reset;
    pend_edge = edge_array;
    pend_ref  = reference_pixel;
    pend_str  = filter_strength;
  end

  task automatic scramble_inputs();
    is_left      = 1'($urandom);
    edge_avail   = 1'($urandom);
    corner_avail = 1'($urandom);
    num_avail    = 4'($urandom);
    blk_wh       = 8'($urandom);
    angle_delta  = 7'($urandom);
    filter_type  = 1'($urandom);
  endtask

  task automatic run_gather(input bit il, input bit ea, input bit ca, input logic [3:0] na,
                            input logic [7:0] wh, input logic [6:0] d, input bit ft,
                            input int lat, input int hold);
    int n, exp_reads, exp_lat, cyc, seen;
    logic [29:0] exp_e, exp_ref;
    n         = (na == 0) ? 1 : ((na > SIZE) ? SIZE : int'(na));
    exp_reads = ea ? n + int'(ca) : 0;
    exp_lat   = exp_reads * (lat + 1) + 2;
    exp_ref   = !ea ? splat(10'd512) : (ca ? mem[SIZE] : mem[0]);

    @(negedge clk);
    lat_cfg = lat; out_ready = 1'b0;
    is_left = il; edge_avail = ea; corner_avail = ca; num_avail = na;
    blk_wh = wh; angle_delta = d; filter_type = ft; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    cyc = 1; seen = 0;
    while (!out_valid && cyc < 300) begin
      if (rd_req && rd_valid) seen++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("read_count", seen, exp_reads);
    chk("out_valid", out_valid, 1'b1);
    for (int i = 0; i < SIZE; i++) begin
      exp_e = !ea ? splat(il ? 10'd513 : 10'd511) : mem[(i < n) ? i : n - 1];
      chk($sformatf("edge[%0d]", i), edge_array[i*30 +: 30], exp_e);
    end
    chk("ref_pixel", reference_pixel, exp_ref);
    chk("strength", filter_strength, model_strength(int'(wh), int'(d), ft));

    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_rd_req", rd_req, 1'b0);
    @(negedge clk);
    chk("idle2_out_valid", out_valid, 1'b0);
    chk("idle2_rd_req", rd_req, 1'b0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i <= SIZE; i++) mem[i] = 30'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    is_left = 0; edge_avail = 0; corner_avail = 0; num_avail = 0;
    blk_wh = 0; angle_delta = 0; filter_type = 0;
    randomize_mem();
    repeat (3) @(negedge clk);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_rd_addr", rd_addr, 4'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_strength", filter_strength, 10'd0);
    chk("rst_ref", reference_pixel, 30'd0);
    chk("rst_edge", edge_array, '0);
    reset = 1'b0;

    // Full edge with corner, Y = 10*i, zero-wait.
    for (int i = 0; i < SIZE; i++) mem[i] = 30'(10 * i);
    mem[SIZE] = {10'd300, 10'd200, 10'd100};
    run_gather(0, 1, 1, 4'd8, 8'd16, 7'd10, 0, 0, 0);
    chk("y_ramp_edge7", edge_array[7*30 +: 10], 10'd70);

    // Three readable pixels, tail padded from the last one.
    mem[0] = 30'd5; mem[1] = 30'd6; mem[2] = 30'd7;
    run_gather(0, 1, 0, 4'd3, 8'd20, 7'd3, 1, 0, 1);
    chk("pad_edge5", edge_array[5*30 +: 30], 30'd7);

    // No edge, left column, no corner; above-row variant.
    run_gather(1, 0, 0, 4'd5, 8'd8, 7'd0, 0, 0, 0);
    run_gather(0, 0, 1, 4'd5, 8'd8, 7'd0, 0, 0, 0);

    // Strength corner cases with literal expectations.
    run_gather(0, 0, 0, 4'd1, 8'd24, 7'd16, 0, 0, 0);
    chk("str_24_16_t0", filter_strength, 10'd2);
    run_gather(0, 0, 0, 4'd1, 8'd8, 7'd64, 1, 0, 0);
    chk("str_8_64_t1", filter_strength, 10'd2);
    run_gather(0, 0, 0, 4'd1, 8'd8, 7'd55, 0, 0, 0);
    chk("str_8_55_t0", filter_strength, 10'd0);
    run_gather(0, 0, 0, 4'd1, 8'd40, 7'd1, 1, 0, 0);
    chk("str_40_1_t1", filter_strength, 10'd3);

    // Count clamping, slow reads and a long consumer stall.
    randomize_mem();
    run_gather(0, 1, 1, 4'd0, 8'd30, 7'd33, 0, 3, 5);
    run_gather(1, 1, 0, 4'd15, 8'd12, 7'd50, 1, 3, 5);

    // Reset in the middle of an edge fetch, then a stray rd_valid.
    randomize_mem();
    @(negedge clk);
    lat_cfg = 3; is_left = 0; edge_avail = 1; corner_avail = 1; num_avail = 4'd8;
    blk_wh = 8'd40; angle_delta = 7'd20; filter_type = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_fetch_rd_req", rd_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_rd_req", rd_req, 1'b0);
    chk("mrst_rd_addr", rd_addr, 4'd0);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_strength", filter_strength, 10'd0);
    chk("mrst_ref", reference_pixel, 30'd0);
    chk("mrst_edge", edge_array, '0);
    late_valid = 1'b1;
    @(negedge clk);
    late_valid = 1'b0;
    chk("late_edge", edge_array, '0);
    chk("late_ref", reference_pixel, 30'd0);
    @(negedge clk);
    chk("late_rd_req", rd_req, 1'b0);
    chk("late_out_valid", out_valid, 1'b0);
    run_gather(0, 1, 1, 4'd6, 8'd28, 7'd5, 0, 1, 2);

    // Randomized gathers.
    for (int t = 0; t < 40; t++) begin
      randomize_mem();
      run_gather(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 60)),
                 7'($urandom_range(0, 127)), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 4));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/intra_edge_gather.md
INTRA_EDGE_GATHER -- requirements
Module: intra_edge_gather

Interface
REQ-001 Parameter SIZE, default 8, edge length in pixels.
REQ-002 Parameter BIT_DEPTH, default 10, bits per colour component.
REQ-003 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port start  in  1  begins one gather; sampled only in IDLE.
REQ-006 Port is_left  in  1  1 = left column, 0 = above row; latched at start.
REQ-007 Port edge_avail  in  1  edge neighbours exist; latched at start.
REQ-008 Port corner_avail  in  1  top-left neighbour exists; latched at start.
REQ-009 Port num_avail  in  4  count of readable edge pixels, 1..SIZE; latched at start; 0 treated as 1, >SIZE treated as SIZE.
REQ-010 Port blk_wh  in  8  block width plus height; latched at start.
REQ-011 Port angle_delta  in  7  absolute prediction angle delta d; latched at start.
REQ-012 Port filter_type  in  1  smooth-neighbour filter type; latched at start.
REQ-013 Port rd_req  out  1  neighbour read request, held high until rd_valid.
REQ-014 Port rd_addr  out  4  0..SIZE-1 = edge index, SIZE = corner pixel.
REQ-015 Port rd_valid  in  1  read data valid; completes the outstanding request.
REQ-016 Port rd_data  in  30  pixel, Y[9:0], U[19:10], V[29:20].
REQ-017 Port out_valid  out  1  edge set ready for the edge filter.
REQ-018 Port out_ready  in  1  consumer accepts the set.
REQ-019 Port reference_pixel  out  30  corner pixel, packed as rd_data.
REQ-020 Port edge_array  out  30 x SIZE  gathered edge, packed as rd_data.
REQ-021 Port filter_strength  out  10  0..3, zero-extended.

Function
REQ-022 FSM states: IDLE, FETCH_EDGE, FETCH_CORNER, FILL, PRESENT.
REQ-023 IDLE with start=1: latch inputs; go to FETCH_EDGE if edge_avail, else FILL.
REQ-024 Only one read outstanding; rd_addr and rd_req stable while rd_req=1 and rd_valid=0.
REQ-025 FETCH_EDGE: read indices 0..num_avail-1 in order; after the last rd_valid, go to FETCH_CORNER if corner_avail, else FILL.
REQ-026 FETCH_CORNER: one read at rd_addr=SIZE; on rd_valid, store reference_pixel; go to FILL.
REQ-027 FILL (exactly one cycle): edge indices >= num_avail take edge[num_avail-1]; go to PRESENT.
REQ-028 Edge unavailable: every edge component is 2^(BIT_DEPTH-1)-1 (511) if is_left=0, else 2^(BIT_DEPTH-1)+1 (513).
REQ-029 Corner unavailable: reference_pixel = edge[0] if edge_avail, else 512 in every component.
REQ-030 filter_strength is computed from the latched blk_wh, d and filter_type and registered in the start cycle.
REQ-031 filter_type=0: blk_wh<=8: d>=56 gives 1; <=16: d>=40 gives 1; <=24: d>=8/16/32 gives 1/2/3; <=32: d>=1/4/32 gives 1/2/3; else d>=1 gives 3; otherwise 0.
REQ-032 filter_type=1: blk_wh<=8: d>=40/64 gives 1/2; <=16: d>=20/48 gives 1/2; <=24: d>=4 gives 3; else d>=1 gives 3; otherwise 0.
REQ-033 PRESENT: out_valid=1; outputs held stable until out_ready=1; in that cycle, return to IDLE.
REQ-034 start outside IDLE is ignored; rd_valid while rd_req=0 is ignored.
REQ-035 Latency with zero-wait reads: out_valid rises num_avail + corner_avail + 2 cycles after start.
REQ-036 start asserted in the out_ready handshake cycle is ignored; a new gather needs start in IDLE.

Reset
REQ-037 reset=1 forces IDLE in the same clock edge, including mid-fetch; an outstanding read is abandoned and its late rd_valid is ignored.
REQ-038 Reset values: rd_req=0, rd_addr=0, out_valid=0, filter_strength=0, reference_pixel=0, all edge_array entries 0.

Structure
REQ-039 Shared package intra_pkg holds pixel_t (30-bit packed), the component field offsets, the base values 511/512/513, and the FSM state enum.
REQ-040 Strength selection is the single combinational sub-module intra_edge_strength_sel (blk_wh, d, filter_type -> 2-bit strength).

Verification
REQ-041 edge_avail=1, corner_avail=1, num_avail=8, zero-wait reads returning Y=10*i: edge Y=0,10..70; ref = corner data; out_valid 11 cycles after start.
REQ-042 num_avail=3, pixels Y=5,6,7: edge Y = 5,6,7,7,7,7,7,7.
REQ-043 edge_avail=0, is_left=1, corner_avail=0: no rd_req; all edge components 513; ref 512; out_valid 2 cycles after start.
REQ-044 Strength: (blk_wh=24, d=16, type 0) gives 2; (8, 64, type 1) gives 2; (8, 55, type 0) gives 0; (40, 1, type 1) gives 3.
REQ-045 rd_valid delayed 3 cycles on each read: rd_addr and rd_req hold stable; out_ready held low 5 cycles: outputs stay constant.
REQ-046 reset pulsed mid-FETCH_EDGE, then a late rd_valid: outputs return to REQ-038 values; late data is not captured; a following start works normally.
